// File: rtl/pattern_sequencer.sv
// Triggered pattern generator: plays a stored WIDTH-bit pattern once or in a loop.
// Optional build macro PATTERN_SEQUENCER_RETRIGGER_EN lets trig restart a running pattern.
module pattern_sequencer #(
    parameter int WIDTH  = 1,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_data,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic              cfg_loop,
    input  logic              trig,
    input  logic              abort,
    output logic [WIDTH-1:0]  out,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ZERO = '0;
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

`ifdef PATTERN_SEQUENCER_RETRIGGER_EN
    localparam logic RETRIGGER = 1'b1;
`else
    localparam logic RETRIGGER = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              loop_q, loop_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    // Reads below see the pre-write contents, so a same-edge write shows up only on later steps.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mem_q[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        loop_d  = loop_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                out_d  = '0;
                busy_d = 1'b0;
                if (trig && !abort) begin
                    state_d = RUN;
                    idx_d   = IDX_ZERO;
                    out_d   = mem_q[IDX_ZERO];
                    busy_d  = 1'b1;
                    len_d   = cfg_len;
                    loop_d  = cfg_loop;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = IDX_ZERO;
                    out_d   = '0;
                    busy_d  = 1'b0;
                end else if (RETRIGGER && trig) begin
                    idx_d  = IDX_ZERO;
                    out_d  = mem_q[IDX_ZERO];
                    len_d  = cfg_len;
                    loop_d = cfg_loop;
                end else if (idx_q == len_q) begin
                    idx_d = IDX_ZERO;
                    if (loop_q) begin
                        out_d = mem_q[IDX_ZERO];
                    end else begin
                        state_d = IDLE;
                        out_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + IDX_ONE;
                    out_d = mem_q[idx_q + IDX_ONE];
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = IDX_ZERO;
                out_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
